// File: rtl/if_stage.sv
// Instruction-fetch stage: next-PC selection, single-outstanding inst_sram reads,
// instruction buffering toward decode, and branch redirect with wrong-path discard.
module if_stage #(
    parameter logic [31:0] RESET_PC        = 32'h1c00_0000,
    parameter int          FS_TO_DS_BUS_WD = 64,
    parameter int          BR_BUS_WD       = 34
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       ds_allowin,
    input  logic [BR_BUS_WD-1:0]       br_bus,
    output logic                       fs_to_ds_valid,
    output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
    output logic                       inst_sram_req,
    output logic                       inst_sram_wr,
    output logic [1:0]                 inst_sram_size,
    output logic [3:0]                 inst_sram_wstrb,
    output logic [31:0]                inst_sram_addr,
    output logic [31:0]                inst_sram_wdata,
    input  logic                       inst_sram_addr_ok,
    input  logic                       inst_sram_data_ok,
    input  logic [31:0]                inst_sram_rdata
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

    state_t      state, state_nx;
    logic [31:0] seq_pc, fs_pc, inst_buf, br_buf_target, held_addr;
    logic        br_buf_valid, cancel, req_held;

    logic        br_stall, br_taken, redirect;
    logic [31:0] br_target;
    logic        pend_valid, wrong_fetch, fire;
    logic [31:0] pend_target, nextpc;
    logic        req_raw, out_valid;
    logic [31:0] inst;

    assign {br_stall, br_taken, br_target} = br_bus;
    assign redirect = br_taken & ~br_stall;

    // A redirect seen this cycle takes priority over one buffered earlier.
    assign pend_valid  = redirect | br_buf_valid;
    assign pend_target = redirect ? br_target : br_buf_target;
    assign nextpc      = pend_valid ? pend_target : seq_pc;

    assign inst_sram_addr = req_held ? held_addr : nextpc;
    assign fire           = inst_sram_req & inst_sram_addr_ok;
    // A frozen request issued before a redirect fetches the wrong path.
    assign wrong_fetch    = pend_valid & (inst_sram_addr != pend_target);

    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'd2;
    assign inst_sram_wstrb = 4'h0;
    assign inst_sram_wdata = 32'h0;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_REQ;
        else         state <= state_nx;
    end

    // NOTE: each always_comb assigns defaults first so no path leaves a signal unassigned (no latches).
    always_comb begin
        state_nx = state;
        case (state)
            S_REQ:  if (fire) state_nx = S_WAIT;
            S_WAIT: begin
                if (inst_sram_data_ok) begin
                    if (cancel || ds_allowin || redirect) state_nx = S_REQ;
                    else                                   state_nx = S_HOLD;
                end
            end
            S_HOLD: if (ds_allowin || redirect) state_nx = S_REQ;
            default: state_nx = S_REQ;
        endcase
    end

    always_comb begin
        req_raw   = 1'b0;
        out_valid = 1'b0;
        inst      = inst_buf;
        case (state)
            S_REQ:  req_raw = ~(br_taken & br_stall) | req_held;
            S_WAIT: begin
                out_valid = inst_sram_data_ok & ~cancel;
                inst      = inst_sram_rdata;
            end
            S_HOLD: out_valid = 1'b1;
            default: ;
        endcase
        inst_sram_req  = resetn & req_raw;
        fs_to_ds_valid = resetn & out_valid;
        fs_to_ds_bus   = fs_to_ds_valid ? {inst, fs_pc} : '0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            seq_pc        <= RESET_PC;
            fs_pc         <= 32'h0;
            inst_buf      <= 32'h0;
            cancel        <= 1'b0;
            br_buf_valid  <= 1'b0;
            br_buf_target <= 32'h0;
            req_held      <= 1'b0;
            held_addr     <= 32'h0;
        end else begin
            if (inst_sram_req && !inst_sram_addr_ok) begin
                req_held  <= 1'b1;
                held_addr <= inst_sram_addr;
            end else if (fire) begin
                req_held  <= 1'b0;
            end

            if (fire) begin
                fs_pc  <= inst_sram_addr;
                seq_pc <= inst_sram_addr + 32'd4;
                if (wrong_fetch) begin
                    cancel        <= 1'b1;
                    br_buf_valid  <= 1'b1;
                    br_buf_target <= pend_target;
                end else begin
                    br_buf_valid  <= 1'b0;
                end
            end else if (redirect) begin
                br_buf_valid  <= 1'b1;
                br_buf_target <= br_target;
            end

            if (state == S_WAIT) begin
                if (inst_sram_data_ok) begin
                    if (cancel) cancel <= 1'b0;
                    else if (!ds_allowin && !redirect) inst_buf <= inst_sram_rdata;
                end else if (redirect) begin
                    cancel <= 1'b1;
                end
            end
        end
    end

endmodule
